// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: access codes, FSM states
// and small decode helpers used by both the top and the lane mapper.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // access size in bytes: 1, 2 or 4
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic [31:0] lsu_extend(input logic [31:0] v,
                                               input logic [2:0]  size,
                                               input logic        sgn);
        case (size)
            3'd1:    return sgn ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
            3'd2:    return sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_map.sv
// Maps one bus beat of an access onto byte lanes (big-endian: lane 0 = MSB).
// i_pos is the lane where access byte 0 would sit; negative for a second beat.
module lsu_lane_map
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [4:0]          i_pos,
    input  logic        [2:0]          i_size,
    input  logic        [31:0]         i_wdata,
    input  logic        [DATA_W-1:0]   i_rdata,
    output logic        [DATA_W/8-1:0] o_sel,
    output logic        [DATA_W-1:0]   o_wdata,
    output logic        [31:0]         o_rbytes,
    output logic        [3:0]          o_rmask
);

    localparam int NL = lane_count(DATA_W);

    int         p;
    int         sz;
    int         j;
    logic [1:0] bi;

    // j = access byte carried by lane l; bi = its byte position in the
    // right-justified 32-bit value (byte 0 is the most significant one)
    always_comb begin
        o_sel    = '0;
        o_wdata  = '0;
        o_rbytes = '0;
        o_rmask  = '0;
        p        = int'(i_pos);
        sz       = int'(i_size);
        j        = 0;
        bi       = '0;
        for (int l = 0; l < NL; l++) begin
            j = l - p;
            if (j >= 0 && j < sz) begin
                bi                          = 2'(sz - 1 - j);
                o_sel[NL-1-l]               = 1'b1;
                o_wdata[(NL-1-l)*8 +: 8]    = i_wdata[{bi, 3'b000} +: 8];
                o_rbytes[{bi, 3'b000} +: 8] = i_rdata[(NL-1-l)*8 +: 8];
                o_rmask[bi]                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_store_seq.sv
// Load/store sequencer: computes the effective address, issues one or two
// bus beats (or traps a misaligned access) and returns an extended load result.
module load_store_seq
    import lsu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SPLIT_EN = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [2:0]          i_op,
    input  logic [31:0]         i_base,
    input  logic [15:0]         i_offset,
    input  logic [31:0]         i_wdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [31:0]         o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_sel,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_done,
    output logic [31:0]         o_rdata,
    output logic                o_bad_addr
);

    localparam int NL = lane_count(DATA_W);
    localparam int LW = $clog2(NL);

    lsu_state_e    state_q, state_d;
    logic [31:0]   addr_q,  addr_d;
    logic [LW-1:0] off_q,   off_d;
    logic [2:0]    size_q,  size_d;
    logic          we_q,    we_d;
    logic          sgn_q,   sgn_d;
    logic          two_q,   two_d;
    logic          bad_q,   bad_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   acc_q,   acc_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   ea;
    logic [LW-1:0] req_off;
    logic [2:0]    req_size;
    logic          misal;
    logic          crosses;
    logic          trap;

    always_comb begin
        ea       = i_base + {{16{i_offset[15]}}, i_offset};
        req_off  = ea[LW-1:0];
        req_size = op_size(i_op);
        misal    = (req_size == 3'd2 && ea[0]) || (req_size == 3'd4 && ea[1:0] != 2'b00);
        crosses  = (int'(req_off) + int'(req_size)) > NL;
        trap     = misal && (SPLIT_EN == 0);
    end

    // per-beat lane mapping; beat 1 starts NL lanes before beat 0
    logic signed [4:0]    pos0, pos1;
    logic [NL-1:0]        sel0, sel1;
    logic [DATA_W-1:0]    mw0, mw1;
    logic [31:0]          rb0, rb1;
    logic [3:0]           rm0, rm1;

    assign pos0 = signed'({{(5-LW){1'b0}}, off_q});
    assign pos1 = pos0 - $signed(5'(NL));

    lsu_lane_map #(.DATA_W(DATA_W)) u_map0 (
        .i_pos    (pos0),
        .i_size   (size_q),
        .i_wdata  (wdata_q),
        .i_rdata  (i_mem_rdata),
        .o_sel    (sel0),
        .o_wdata  (mw0),
        .o_rbytes (rb0),
        .o_rmask  (rm0)
    );

    lsu_lane_map #(.DATA_W(DATA_W)) u_map1 (
        .i_pos    (pos1),
        .i_size   (size_q),
        .i_wdata  (wdata_q),
        .i_rdata  (i_mem_rdata),
        .o_sel    (sel1),
        .o_wdata  (mw1),
        .o_rbytes (rb1),
        .o_rmask  (rm1)
    );

    logic        in_b0, in_b1, busy;
    logic [31:0] cur_rb, mask_bits, merged;
    logic [3:0]  cur_rm;

    assign in_b0 = (state_q == ST_BEAT0);
    assign in_b1 = (state_q == ST_BEAT1);
    assign busy  = in_b0 || in_b1;

    // fold this beat's bytes into whatever earlier beats already gathered
    always_comb begin
        cur_rb    = in_b1 ? rb1 : rb0;
        cur_rm    = in_b1 ? rm1 : rm0;
        mask_bits = '0;
        for (int k = 0; k < 4; k++) begin
            mask_bits[k*8 +: 8] = {8{cur_rm[k]}};
        end
        merged = (acc_q & ~mask_bits) | (cur_rb & mask_bits);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        two_d   = two_q;
        bad_d   = bad_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = ea & ~32'(NL - 1);
                    off_d   = req_off;
                    size_d  = req_size;
                    we_d    = op_is_store(i_op);
                    sgn_d   = op_is_signed(i_op);
                    two_d   = crosses;
                    wdata_d = i_wdata;
                    acc_d   = '0;
                    if (trap) begin
                        state_d = ST_RESP;
                        bad_d   = 1'b1;
                    end else begin
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (i_mem_ack) begin
                    acc_d = merged;
                    if (in_b0 && two_q) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d = ST_RESP;
                        bad_d   = 1'b0;
                        if (!we_q) rdata_d = lsu_extend(merged, size_q, sgn_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            two_q   <= 1'b0;
            bad_q   <= 1'b0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            two_q   <= two_d;
            bad_q   <= bad_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        o_mem_req   = busy;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_sel   = '0;
        o_mem_wdata = '0;
        if (busy) begin
            o_mem_we    = we_q;
            o_mem_addr  = in_b1 ? addr_q + 32'(NL) : addr_q;
            o_mem_sel   = in_b1 ? sel1 : sel0;
            o_mem_wdata = we_q ? (in_b1 ? mw1 : mw0) : '0;
        end
        o_done = (state_q == ST_RESP);
    end

    assign o_rdata    = rdata_q;
    assign o_bad_addr = bad_q;

endmodule

// File: tb/tb_load_store_seq.sv
// Bench for load_store_seq: three instances (32-bit trap, 32-bit split,
// 64-bit trap) driven from one vector table plus reset / stray-ack sequences.
module tb_load_store_seq;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [2:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] wd;
    logic        ack;
    logic [63:0] mrd;
    int          cur;
    logic [2:0]  ack_v;

    always #5 clk = ~clk;
    assign ack_v = ack ? (3'b001 << cur) : 3'b000;

    logic        rdy[3], mreq[3], mwe[3], done[3], bad[3];
    logic [31:0] maddr[3], ord[3];
    logic [7:0]  msel[3];
    logic [63:0] mwd[3];

    logic [3:0]  sel_a, sel_b;
    logic [31:0] wd_a, wd_b;
    logic [7:0]  sel_c;
    logic [63:0] wd_c;

    assign msel[0] = {4'd0, sel_a};
    assign msel[1] = {4'd0, sel_b};
    assign msel[2] = sel_c;
    assign mwd[0]  = {32'd0, wd_a};
    assign mwd[1]  = {32'd0, wd_b};
    assign mwd[2]  = wd_c;

    load_store_seq #(.DATA_W(32), .SPLIT_EN(0)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld[0]), .o_req_ready(rdy[0]),
        .i_op(op), .i_base(base), .i_offset(off), .i_wdata(wd),
        .o_mem_req(mreq[0]), .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]), .o_mem_sel(sel_a),
        .o_mem_wdata(wd_a), .i_mem_ack(ack_v[0]), .i_mem_rdata(mrd[31:0]),
        .o_done(done[0]), .o_rdata(ord[0]), .o_bad_addr(bad[0])
    );

    load_store_seq #(.DATA_W(32), .SPLIT_EN(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld[1]), .o_req_ready(rdy[1]),
        .i_op(op), .i_base(base), .i_offset(off), .i_wdata(wd),
        .o_mem_req(mreq[1]), .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]), .o_mem_sel(sel_b),
        .o_mem_wdata(wd_b), .i_mem_ack(ack_v[1]), .i_mem_rdata(mrd[31:0]),
        .o_done(done[1]), .o_rdata(ord[1]), .o_bad_addr(bad[1])
    );

    load_store_seq #(.DATA_W(64), .SPLIT_EN(0)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld[2]), .o_req_ready(rdy[2]),
        .i_op(op), .i_base(base), .i_offset(off), .i_wdata(wd),
        .o_mem_req(mreq[2]), .o_mem_we(mwe[2]), .o_mem_addr(maddr[2]), .o_mem_sel(sel_c),
        .o_mem_wdata(wd_c), .i_mem_ack(ack_v[2]), .i_mem_rdata(mrd),
        .o_done(done[2]), .o_rdata(ord[2]), .o_bad_addr(bad[2])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        bad;
        logic        chk_rd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          d;
        logic [2:0]  op;
        logic [31:0] base;
        logic [15:0] off;
        logic [31:0] wd;
        int          nb;
        int          aw;
        logic [31:0] a0;
        logic [7:0]  s0;
        logic [63:0] w0;
        logic [63:0] r0;
        logic [31:0] a1;
        logic [7:0]  s1;
        logic [63:0] w1;
        logic [63:0] r1;
        logic [31:0] exp_rd;
        logic        exp_bad;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(int d, logic [2:0] o, logic [31:0] b, logic [15:0] f,
                                logic [31:0] w, int nb, int aw,
                                logic [31:0] a0, logic [7:0] s0, logic [63:0] w0, logic [63:0] r0,
                                logic [31:0] a1, logic [7:0] s1, logic [63:0] w1, logic [63:0] r1,
                                logic [31:0] er, logic eb);
        vec_t v;
        v.d = d; v.op = o; v.base = b; v.off = f; v.wd = w; v.nb = nb; v.aw = aw;
        v.a0 = a0; v.s0 = s0; v.w0 = w0; v.r0 = r0;
        v.a1 = a1; v.s1 = s1; v.w1 = w1; v.r1 = r1;
        v.exp_rd = er; v.exp_bad = eb;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        exp_t        e;
        int          t;
        int          lim;
        logic [31:0] ba[2];
        logic [7:0]  bs[2];
        logic [63:0] bw[2];
        logic [63:0] br[2];
        ba[0] = v.a0; ba[1] = v.a1;
        bs[0] = v.s0; bs[1] = v.s1;
        bw[0] = v.w0; bw[1] = v.w1;
        br[0] = v.r0; br[1] = v.r1;
        cur = v.d;
        @(negedge clk);
        chk({tag, " ready"}, 64'(rdy[v.d]), 64'(1));
        op = v.op; base = v.base; off = v.off; wd = v.wd;
        vld = 3'b001 << v.d;
        e.rd = v.exp_rd; e.bad = v.exp_bad;
        e.chk_rd = !op_is_store(v.op) && !v.exp_bad;
        sbq.push_back(e);
        @(negedge clk);
        t = 1;
        vld = '0;
        if (v.nb == 0) chk({tag, " no_req"}, 64'(mreq[v.d]), 64'(0));
        for (int b = 0; b < v.nb; b++) begin
            for (int w = 0; w <= v.aw; w++) begin
                chk($sformatf("%s b%0d req", tag, b),  64'(mreq[v.d]), 64'(1));
                chk($sformatf("%s b%0d addr", tag, b), 64'(maddr[v.d]), 64'(ba[b]));
                chk($sformatf("%s b%0d sel", tag, b),  64'(msel[v.d]), 64'(bs[b]));
                chk($sformatf("%s b%0d we", tag, b),   64'(mwe[v.d]), 64'(op_is_store(v.op)));
                if (op_is_store(v.op))
                    chk($sformatf("%s b%0d wdata", tag, b), mwd[v.d], bw[b]);
                if (w == v.aw) begin
                    ack = 1'b1;
                    mrd = br[b];
                end
                @(negedge clk);
                t++;
                ack = 1'b0;
            end
        end
        lim = 0;
        while (!done[v.d] && lim < 10) begin
            @(negedge clk);
            t++;
            lim++;
        end
        chk({tag, " done"}, 64'(done[v.d]), 64'(1));
        chk({tag, " latency"}, 64'(t), 64'(1 + v.nb * (v.aw + 1)));
        e = sbq.pop_front();
        if (e.chk_rd) chk({tag, " rdata"}, 64'(ord[v.d]), 64'(e.rd));
        chk({tag, " bad"}, 64'(bad[v.d]), 64'(e.bad));
        @(negedge clk);
        chk({tag, " pulse"}, 64'(done[v.d]), 64'(0));
        chk({tag, " idle"}, 64'(rdy[v.d]), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; vld = '0; op = '0; base = '0; off = '0; wd = '0;
        ack = 1'b0; mrd = '0; cur = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst d%0d ready", d), 64'(rdy[d]), 64'(1));
            chk($sformatf("rst d%0d req", d),   64'(mreq[d]), 64'(0));
            chk($sformatf("rst d%0d we", d),    64'(mwe[d]), 64'(0));
            chk($sformatf("rst d%0d done", d),  64'(done[d]), 64'(0));
            chk($sformatf("rst d%0d bad", d),   64'(bad[d]), 64'(0));
            chk($sformatf("rst d%0d rdata", d), 64'(ord[d]), 64'(0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //         d  op      base          off       wd            nb aw a0            s0     w0                  r0                     a1          s1     w1            r1            exp           bad
        vt.push_back(mk(0, OP_LW,  32'h100,      16'h0,    32'h0,        1, 0, 32'h100,      8'h0F, 64'h0,              64'h11223344,          32'h0,      8'h0,  64'h0,        64'h0,        32'h11223344, 1'b0));
        vt.push_back(mk(0, OP_LB,  32'h100,      16'h3,    32'h0,        1, 0, 32'h100,      8'h01, 64'h0,              64'h000000F0,          32'h0,      8'h0,  64'h0,        64'h0,        32'hFFFFFFF0, 1'b0));
        vt.push_back(mk(0, OP_LBU, 32'h100,      16'h3,    32'h0,        1, 1, 32'h100,      8'h01, 64'h0,              64'h000000F0,          32'h0,      8'h0,  64'h0,        64'h0,        32'h000000F0, 1'b0));
        vt.push_back(mk(0, OP_LH,  32'h104,      16'hFFFD, 32'h0,        0, 0, 32'h0,        8'h0,  64'h0,              64'h0,                 32'h0,      8'h0,  64'h0,        64'h0,        32'h0,        1'b1));
        vt.push_back(mk(1, OP_SW,  32'h102,      16'h0,    32'hAABBCCDD, 2, 1, 32'h100,      8'h03, 64'h0000AABB,       64'h0,                 32'h104,    8'h0C, 64'hCCDD0000, 64'h0,        32'h0,        1'b0));
        vt.push_back(mk(2, OP_LW,  32'h100,      16'h4,    32'h0,        1, 0, 32'h100,      8'h0F, 64'h0,              64'h00000000CAFEBABE,  32'h0,      8'h0,  64'h0,        64'h0,        32'hCAFEBABE, 1'b0));
        vt.push_back(mk(0, OP_SH,  32'h200,      16'h2,    32'hFFFF1234, 1, 2, 32'h200,      8'h03, 64'h00001234,       64'h0,                 32'h0,      8'h0,  64'h0,        64'h0,        32'h0,        1'b0));
        vt.push_back(mk(0, OP_LHU, 32'h200,      16'h0,    32'h0,        1, 0, 32'h200,      8'h0C, 64'h0,              64'h80017777,          32'h0,      8'h0,  64'h0,        64'h0,        32'h00008001, 1'b0));
        vt.push_back(mk(0, OP_LH,  32'h200,      16'h0,    32'h0,        1, 0, 32'h200,      8'h0C, 64'h0,              64'h80017777,          32'h0,      8'h0,  64'h0,        64'h0,        32'hFFFF8001, 1'b0));
        vt.push_back(mk(1, OP_LW,  32'hFFFFFFFE, 16'h0,    32'h0,        2, 0, 32'hFFFFFFFC, 8'h03, 64'h0,              64'h0000A1B2,          32'h0,      8'h0C, 64'h0,        64'hC3D40000, 32'hA1B2C3D4, 1'b0));
        vt.push_back(mk(1, OP_LH,  32'h101,      16'h0,    32'h0,        1, 0, 32'h100,      8'h06, 64'h0,              64'h00ABCD00,          32'h0,      8'h0,  64'h0,        64'h0,        32'hFFFFABCD, 1'b0));
        vt.push_back(mk(2, OP_SB,  32'h100,      16'h7,    32'h1234565A, 1, 0, 32'h100,      8'h01, 64'h5A,             64'h0,                 32'h0,      8'h0,  64'h0,        64'h0,        32'h0,        1'b0));
        vt.push_back(mk(2, OP_LW,  32'h100,      16'h6,    32'h0,        0, 0, 32'h0,        8'h0,  64'h0,              64'h0,                 32'h0,      8'h0,  64'h0,        64'h0,        32'h0,        1'b1));
        vt.push_back(mk(0, OP_SW,  32'h400,      16'hFF00, 32'hDEADBEEF, 1, 1, 32'h300,      8'h0F, 64'hDEADBEEF,       64'h0,                 32'h0,      8'h0,  64'h0,        64'h0,        32'h0,        1'b0));
        vt.push_back(mk(1, OP_LHU, 32'h107,      16'h0,    32'h0,        2, 1, 32'h104,      8'h01, 64'h0,              64'h000000FE,          32'h108,    8'h08, 64'h0,        64'h12000000, 32'h0000FE12, 1'b0));
        vt.push_back(mk(2, OP_LB,  32'h100,      16'h0,    32'h0,        1, 0, 32'h100,      8'h80, 64'h0,              64'h8000000000000000,  32'h0,      8'h0,  64'h0,        64'h0,        32'hFFFFFF80, 1'b0));

        foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

        // stray acks while idle must not start or finish anything
        cur = 0;
        @(negedge clk);
        ack = 1'b1;
        mrd = 64'h5555AAAA;
        repeat (2) begin
            @(negedge clk);
            chk("stray req", 64'(mreq[0]), 64'(0));
            chk("stray done", 64'(done[0]), 64'(0));
            chk("stray ready", 64'(rdy[0]), 64'(1));
        end
        ack = 1'b0;

        // reset in BEAT0 with ack withheld
        @(negedge clk);
        op = OP_LW; base = 32'h100; off = 16'h0; vld = 3'b001;
        @(negedge clk);
        vld = '0;
        chk("mid req", 64'(mreq[0]), 64'(1));
        @(negedge clk);
        chk("mid hold", 64'(mreq[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst req", 64'(mreq[0]), 64'(0));
        chk("mid rst ready", 64'(rdy[0]), 64'(1));
        chk("mid rst done", 64'(done[0]), 64'(0));
        chk("mid rst rdata", 64'(ord[0]), 64'(0));
        chk("mid rst bad", 64'(bad[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post rst done", 64'(done[0]), 64'(0));
            chk("post rst req", 64'(mreq[0]), 64'(0));
        end
        apply(vt[0], "post_rst");

        chk("scoreboard empty", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
